// File: rtl/arcade_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_pkg
// Description : Shared constants for the arcade input conditioning stage:
//               PS/2 scan codes, coin FSM states, CSJUDLR and joystick bit
//               positions.
// Revision    : 1.0 - initial release
// ============================================================================
package arcade_input_pkg;

    // Direction keys are matched on the low 8 bits only (extended bit ignored)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Remaining keys are matched on {extended, code}
    localparam logic [8:0] SC_SPACE = 9'h029;
    localparam logic [8:0] SC_LCTRL = 9'h014;
    localparam logic [8:0] SC_F1    = 9'h005;
    localparam logic [8:0] SC_F2    = 9'h006;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_t;

    // Bit positions inside the core's CSJUDLR buses
    localparam int CSJ_COIN  = 6;
    localparam int CSJ_START = 5;
    localparam int CSJ_FIRE  = 4;
    localparam int CSJ_UP    = 3;
    localparam int CSJ_DOWN  = 2;
    localparam int CSJ_LEFT  = 1;
    localparam int CSJ_RIGHT = 0;

    // Bit positions inside the HPS joystick words
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;

endpackage
`default_nettype wire

// File: rtl/arcade_input_ctrl_coin_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : coin_pulse_gen
// Description : Timed coin pulse generator. A trigger in IDLE produces a
//               coin pulse of COIN_PULSE_CYCLES followed by a mandatory low
//               holdoff of COIN_GAP_CYCLES; triggers while busy are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_pulse_gen
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE_CYCLES = 1200000,
    parameter int COIN_GAP_CYCLES   = 1200000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic trig,
    output logic coin,
    output logic busy
);

    localparam int MAX_CYCLES = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                                COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    // Counter only ever holds load values (max MAX_CYCLES-1) and counts down
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    coin_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;

    // Coin FSM: IDLE -> PULSE -> GAP -> IDLE, each timed by the down-counter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (trig) begin
                        r_state <= ST_PULSE;
                        r_cnt   <= PULSE_LOAD;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign coin = (r_state == ST_PULSE);
    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_ctrl
// Description : Player input conditioning for the galaxian core: PS/2 key
//               decode, merge with both HPS joysticks, orientation remap,
//               registered CSJUDLR outputs and an edge-triggered timed coin.
// Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE_CYCLES = 1200000,
    parameter int COIN_GAP_CYCLES   = 1200000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate_ctl,
    output logic [6:0]  p1_csjudlr,
    output logic [6:0]  p2_csjudlr,
    output logic        coin_busy
);

    logic r_toggle_q, r_primed;
    logic r_up, r_down, r_left, r_right;
    logic r_fire_space, r_fire_ctrl, r_f1, r_f2;
    logic r_start_q;

    logic        w_event, w_pressed;
    logic [15:0] w_joy;
    logic        w_src_up, w_src_down, w_src_left, w_src_right;
    logic        w_up, w_down, w_left, w_right, w_fire;
    logic        w_start1, w_start2, w_start_any, w_trig;
    logic        w_coin, w_busy;
    logic        w_unused_joy;

    assign w_event   = (ps2_key[10] != r_toggle_q);
    assign w_pressed = ps2_key[9];

    // PS/2 decode; the first edge after reset only captures the toggle level
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_toggle_q   <= 1'b0;
            r_primed     <= 1'b0;
            r_up         <= 1'b0;
            r_down       <= 1'b0;
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_fire_space <= 1'b0;
            r_fire_ctrl  <= 1'b0;
            r_f1         <= 1'b0;
            r_f2         <= 1'b0;
        end else if (!r_primed) begin
            r_primed   <= 1'b1;
            r_toggle_q <= ps2_key[10];
        end else if (w_event) begin
            r_toggle_q <= ps2_key[10];
            if (ps2_key[7:0] == SC_UP)    r_up         <= w_pressed;
            if (ps2_key[7:0] == SC_DOWN)  r_down       <= w_pressed;
            if (ps2_key[7:0] == SC_LEFT)  r_left       <= w_pressed;
            if (ps2_key[7:0] == SC_RIGHT) r_right      <= w_pressed;
            if (ps2_key[8:0] == SC_SPACE) r_fire_space <= w_pressed;
            if (ps2_key[8:0] == SC_LCTRL) r_fire_ctrl  <= w_pressed;
            if (ps2_key[8:0] == SC_F1)    r_f1         <= w_pressed;
            if (ps2_key[8:0] == SC_F2)    r_f2         <= w_pressed;
        end
    end

    // Merge: keyboard state ORed with both joysticks (applied after key regs)
    assign w_joy        = joystick_0 | joystick_1;
    assign w_unused_joy = ^w_joy[15:7];
    assign w_src_up     = r_up    | w_joy[JOY_UP];
    assign w_src_down   = r_down  | w_joy[JOY_DOWN];
    assign w_src_left   = r_left  | w_joy[JOY_LEFT];
    assign w_src_right  = r_right | w_joy[JOY_RIGHT];
    assign w_fire       = r_fire_space | r_fire_ctrl | w_joy[JOY_FIRE];
    assign w_start1     = r_f1 | w_joy[JOY_START1];
    assign w_start2     = r_f2 | w_joy[JOY_START2];

    // Horizontal-screen remap rotates the stick a quarter turn
    assign w_up    = rotate_ctl ? w_src_left  : w_src_up;
    assign w_down  = rotate_ctl ? w_src_right : w_src_down;
    assign w_left  = rotate_ctl ? w_src_down  : w_src_left;
    assign w_right = rotate_ctl ? w_src_up    : w_src_right;

    assign w_start_any = w_start1 | w_start2;
    assign w_trig      = w_start_any & ~r_start_q;

    // Registered copy of start_any for rising-edge detection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= w_start_any;
        end
    end

    coin_pulse_gen #(
        .COIN_PULSE_CYCLES (COIN_PULSE_CYCLES),
        .COIN_GAP_CYCLES   (COIN_GAP_CYCLES)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .trig    (w_trig),
        .coin    (w_coin),
        .busy    (w_busy)
    );

    // Output registers feeding the core
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_csjudlr <= '0;
            p2_csjudlr <= '0;
            coin_busy  <= 1'b0;
        end else begin
            p1_csjudlr <= {w_coin, w_start1, w_fire, w_up, w_down, w_left, w_right};
            p2_csjudlr <= {1'b0, w_start2, w_fire, w_up, w_down, w_left, w_right};
            coin_busy  <= w_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arcade_input_ctrl
// Description : Scoreboard bench for arcade_input_ctrl with a behavioural
//               reference model, directed scenarios and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_ctrl;

    localparam int P = 4;
    localparam int G = 3;

    logic        clk_sys;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic        rotate_ctl;
    logic [6:0]  p1_csjudlr, p2_csjudlr;
    logic        coin_busy;

    int n_cmp = 0;
    int n_bad = 0;

    arcade_input_ctrl #(
        .COIN_PULSE_CYCLES (P),
        .COIN_GAP_CYCLES   (G)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .rotate_ctl (rotate_ctl),
        .p1_csjudlr (p1_csjudlr),
        .p2_csjudlr (p2_csjudlr),
        .coin_busy  (coin_busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Reference model: named key table, arithmetic coin window
    // ------------------------------------------------------------------
    bit   ks[string];
    logic [14:0] exp_q[$];

    function automatic string key_name(input logic ext, input logic [7:0] code);
        case (code)
            8'h75: return "up";
            8'h72: return "down";
            8'h6B: return "left";
            8'h74: return "right";
            default: ;
        endcase
        if (!ext) begin
            case (code)
                8'h29: return "space";
                8'h14: return "ctrl";
                8'h05: return "f1";
                8'h06: return "f2";
                default: ;
            endcase
        end
        return "";
    endfunction

    function automatic bit key(input string s);
        return ks.exists(s) ? ks[s] : 1'b0;
    endfunction

    initial begin
        int   edge_n;
        int   last_trig;
        bit   primed, tog, prev_start;
        logic [15:0] joy;
        bit   su, sd, sl, sr, up, dn, lf, rt, fire, s1, s2, coin, busy;
        string nm;
        edge_n = 0; last_trig = -1000; primed = 0; tog = 0; prev_start = 0;
        forever begin
            @(posedge clk_sys);
            edge_n++;
            if (!reset_n) begin
                ks.delete();
                primed = 0;
                prev_start = 0;
                last_trig = -1000;
                exp_q.push_back('0);
            end else begin
                joy  = joystick_0 | joystick_1;
                su   = key("up")    | joy[3];
                sd   = key("down")  | joy[2];
                sl   = key("left")  | joy[1];
                sr   = key("right") | joy[0];
                up   = rotate_ctl ? sl : su;
                dn   = rotate_ctl ? sr : sd;
                lf   = rotate_ctl ? sd : sl;
                rt   = rotate_ctl ? su : sr;
                fire = key("space") | key("ctrl") | joy[4];
                s1   = key("f1") | joy[5];
                s2   = key("f2") | joy[6];
                // A pulse accepted at edge k is visible after edges k+1..k+P,
                // busy after edges k+1..k+P+G
                coin = (edge_n >= last_trig + 1) && (edge_n <= last_trig + P);
                busy = (edge_n >= last_trig + 1) && (edge_n <= last_trig + P + G);
                exp_q.push_back({coin, s1, fire, up, dn, lf, rt,
                                 1'b0, s2, fire, up, dn, lf, rt, busy});
                if ((s1 | s2) && !prev_start && (edge_n >= last_trig + P + G + 1))
                    last_trig = edge_n;
                prev_start = s1 | s2;
                if (!primed) begin
                    primed = 1;
                    tog = ps2_key[10];
                end else if (ps2_key[10] != tog) begin
                    tog = ps2_key[10];
                    nm = key_name(ps2_key[8], ps2_key[7:0]);
                    if (nm != "") ks[nm] = ps2_key[9];
                end
            end
        end
    end

    // Monitor: outputs are presented every cycle; compare away from the edge
    initial begin
        logic [14:0] e;
        forever begin
            @(negedge clk_sys);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (!reset_n) e = '0;
                chk("scoreboard", 32'({p1_csjudlr, p2_csjudlr, coin_busy}), 32'(e));
            end
        end
    end

    task automatic wait_sig(input string name, input bit use_busy, input bit level);
        int i;
        i = 0;
        while (((use_busy ? coin_busy : p1_csjudlr[6]) != level) && i < 30) begin
            tick(1);
            i++;
        end
        chk(name, 32'(use_busy ? coin_busy : p1_csjudlr[6]), 32'(level));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] codes [10];
        int cnt_c, cnt_b, r;
        codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06, 8'h12, 8'h5A};

        // 1: reset with a pending-looking toggle level; no phantom event
        reset_n = 0; ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
        joystick_0 = '0; joystick_1 = '0; rotate_ctl = 0;
        tick(3);
        chk("reset_outputs", 32'({p1_csjudlr, p2_csjudlr, coin_busy}), 32'd0);
        reset_n = 1;
        tick(3);
        chk("prime_no_phantom", 32'({p1_csjudlr, p2_csjudlr, coin_busy}), 32'd0);

        // 2: extended up press then release, 2-cycle latency
        ps2_key = {1'b0, 1'b1, 1'b1, 8'h75};
        tick(1); chk("up_press_lat1", 32'(p1_csjudlr[3]), 32'd0);
        tick(1); chk("up_press_lat2", 32'(p1_csjudlr[3]), 32'd1);
        ps2_key = {1'b1, 1'b0, 1'b0, 8'h75};
        tick(1); chk("up_rel_lat1", 32'(p1_csjudlr[3]), 32'd1);
        tick(1); chk("up_rel_lat2", 32'(p1_csjudlr[3]), 32'd0);

        // 3: rotated joystick left becomes up
        rotate_ctl = 1; joystick_0 = 16'h0002;
        tick(1);
        chk("rot_p1", 32'(p1_csjudlr), 32'h08);
        chk("rot_p2", 32'(p2_csjudlr), 32'h08);
        rotate_ctl = 0; joystick_0 = '0;
        tick(3);

        // 4: start held 20 cycles gives a single 4-cycle coin, 7 busy cycles
        joystick_0[5] = 1'b1;
        cnt_c = 0; cnt_b = 0;
        repeat (20) begin
            tick(1);
            cnt_c += int'(p1_csjudlr[6]);
            cnt_b += int'(coin_busy);
        end
        chk("held_coin_cycles", 32'(cnt_c), 32'd4);
        chk("held_busy_cycles", 32'(cnt_b), 32'd7);
        joystick_0 = '0;
        tick(3);

        // 5: start2 re-rise during PULSE dropped; after busy falls it retriggers
        joystick_1[6] = 1'b1;
        wait_sig("pulse5_start", 0, 1'b1);
        joystick_1[6] = 1'b0; tick(1);
        joystick_1[6] = 1'b1;
        wait_sig("pulse5_busy_fall", 1, 1'b0);
        chk("pulse5_no_retrigger", 32'(p1_csjudlr[6]), 32'd0);
        joystick_1[6] = 1'b0; tick(1);
        joystick_1[6] = 1'b1;
        cnt_c = 0;
        repeat (12) begin tick(1); cnt_c += int'(p1_csjudlr[6]); end
        chk("pulse5_second_coin", 32'(cnt_c), 32'd4);
        joystick_1 = '0;
        tick(3);

        // 6: asynchronous reset mid-pulse, then a clean full pulse
        joystick_0[5] = 1'b1;
        wait_sig("pulse6_start", 0, 1'b1);
        #1 reset_n = 0;
        #1 chk("async_reset", 32'({p1_csjudlr, p2_csjudlr, coin_busy}), 32'd0);
        joystick_0 = '0;
        tick(2);
        reset_n = 1;
        tick(2);
        joystick_0[5] = 1'b1;
        cnt_c = 0;
        repeat (12) begin tick(1); cnt_c += int'(p1_csjudlr[6]); end
        chk("post_reset_coin", 32'(cnt_c), 32'd4);
        joystick_0 = '0;
        tick(3);

        // Random traffic checked by the scoreboard
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 35)
                ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), codes[$urandom_range(0, 9)]};
            if ($urandom_range(0, 3) == 0)
                joystick_0 = 16'($urandom) & (($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h007F);
            if ($urandom_range(0, 3) == 0)
                joystick_1 = 16'($urandom) & 16'h007F;
            if ($urandom_range(0, 49) == 0)
                rotate_ctl = ~rotate_ctl;
            if ($urandom_range(0, 399) == 0) begin
                #1 reset_n = 0;
                tick(2);
                reset_n = 1;
            end
            tick(1);
        end

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
